snitch_fpu_sequencer: RTL and testbench
=======================================

SNITCH_FPU_SEQUENCER -- requirements
Module: snitch_fpu_sequencer

Interface
REQ-001 SHALL have parameter FLEN, default 64, FP register and result width.
REQ-002 SHALL have parameter MaxOutstanding, default 8, maximum FPU operations in flight (2..63).
REQ-003 SHALL have port clk_i  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port issue_valid_i / issue_ready_o  in/out  1/1  instruction offer from core / accept.
REQ-006 SHALL have port issue_rd_i  input  5  destination register index.
REQ-007 SHALL have port issue_rd_is_int_i  input  1  destination is integer regfile.
REQ-008 SHALL have port issue_rs_i / issue_rs_used_i  input  15/3  three FP source indices / per-source use flags.
REQ-009 SHALL have port fpu_valid_o / fpu_ready_i  out/in  1/1  request handshake to FPU wrapper; operand fields bypass this block.
REQ-010 SHALL have port fpu_tag_o  output  6  request tag = {issue_rd_is_int_i, issue_rd_i}.
REQ-011 SHALL have port fpu_out_valid_i / fpu_out_ready_o  in/out  1/1  result handshake from FPU wrapper.
REQ-012 SHALL have port fpu_result_i / fpu_status_i / fpu_tag_i  input  FLEN/5/6  result, fflags, returned tag.
REQ-013 SHALL have port fpr_we_o / fpr_waddr_o / fpr_wdata_o  output  1/5/FLEN  FP regfile write port.
REQ-014 SHALL have port int_wb_valid_o / int_wb_ready_i / int_wb_addr_o / int_wb_data_o  out/in/out/out  1/1/5/32  integer writeback.
REQ-015 SHALL have port fflags_o / fflags_clr_i  out/in  5/1  sticky exception flags / synchronous clear.
REQ-016 SHALL have port outstanding_o / busy_o / error_o  output  6/32/1  in-flight count / FP scoreboard / tag error pulse.

Function
REQ-017 SHALL hold hazard = any used source or FP destination (rd_is_int=0) with busy_q bit set; busy_q is the registered scoreboard only.
REQ-018 SHALL hold full = (outstanding_q == MaxOutstanding).
REQ-019 SHALL drive fpu_valid_o = issue_valid_i & !hazard & !full, issue_ready_o = fpu_ready_i & !hazard & !full; zero-cycle pass-through.
REQ-020 SHALL on issue fire (fpu_valid_o & fpu_ready_i) increment outstanding and, for FP rd, set busy bit rd next cycle.
REQ-021 SHALL drive fpu_out_ready_o = 1 for FP-tag results, int_wb_ready_i for integer-tag results.
REQ-022 SHALL on FP result fire assert fpr_we_o same cycle with waddr = tag[4:0], wdata = fpu_result_i, and clear the busy bit next cycle.
REQ-023 SHALL drive int_wb_valid_o = fpu_out_valid_i & tag[5], addr = tag[4:0], data = fpu_result_i[31:0].
REQ-024 SHALL on any result fire decrement outstanding and OR fpu_status_i into fflags.
REQ-025 SHALL with simultaneous issue and result fire leave outstanding unchanged; same-cycle set and clear of the same busy bit resolves to set.
REQ-026 SHALL stall an issue whose register retires this cycle for one cycle (busy_q-based check).
REQ-027 SHALL with an FP-tag result whose busy bit is clear suppress fpr_we_o, pulse error_o for one cycle, still consume the result, and decrement outstanding.
REQ-028 SHALL with fflags_clr_i and status accumulation in the same cycle load fflags with fpu_status_i only.
REQ-029 SHALL never let outstanding underflow; a result fire at outstanding 0 leaves it 0 and pulses error_o.
REQ-030 SHALL drive outstanding_o, busy_o and fflags_o from registers.

Reset
REQ-031 SHALL on rst_i asynchronously clear outstanding, busy, fflags and error_o to 0; combinational outputs follow from the cleared state.
REQ-032 SHALL discard in-flight bookkeeping when reset is asserted mid-operation; results arriving after reset release follow REQ-027/REQ-029.

Structure
REQ-033 SHALL take FLEN from snitch_pkg; tag layout constants (TagIntBit = 5) belong in snitch_pkg.
REQ-034 SHALL be a single module with no sub-module; scoreboard and counter are inline.

Verification
REQ-035 SHALL cover back-to-back issue of rd=3 then rs1=3 -> second held with issue_ready_o=0 until the cycle after fpr_we_o, waddr=3.
REQ-036 SHALL cover 8 issues with no results -> outstanding_o=8, ninth held; one result -> ninth issues next cycle.
REQ-037 SHALL cover integer-tag result 0x25 with int_wb_ready_i=0 for 3 cycles -> fpu_out_ready_o=0 for 3 cycles, int_wb_addr_o=5 on accept.
REQ-038 SHALL cover status 0x01 then 0x10 -> fflags_o=0x11; clr with status 0x04 same cycle -> fflags_o=0x04.
REQ-039 SHALL cover FP result for tag 0x07 while busy_o[7]=0 -> no write, error_o one-cycle pulse.
REQ-040 SHALL cover rst_i asserted with outstanding=4, busy_o=0x18 -> all zero immediately, without a clock edge.

Source files
------------

// File: rtl/snitch_pkg.sv
// Shared constants for the Snitch FPU sequencer: widths and the result/request tag layout.
package snitch_pkg;

    localparam int unsigned FLEN      = 64;
    localparam int unsigned XLEN      = 32;
    localparam int unsigned RegAddrW  = 5;
    localparam int unsigned NumRegs   = 32;
    localparam int unsigned TagW      = 6;
    localparam int unsigned TagIntBit = 5;
    localparam int unsigned FlagsW    = 5;
    localparam int unsigned CntW      = 6;
    localparam int unsigned NumSrc    = 3;

endpackage

// File: rtl/snitch_fpu_sequencer.sv
// FPU issue/retire sequencer: FP register scoreboard, in-flight counter, result routing
// to the FP regfile or integer writeback, and sticky exception flag accumulation.
module snitch_fpu_sequencer
    import snitch_pkg::*;
#(
    parameter int unsigned FLEN           = snitch_pkg::FLEN,
    parameter int unsigned MaxOutstanding = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          issue_valid_i,
    output logic                          issue_ready_o,
    input  logic [RegAddrW-1:0]           issue_rd_i,
    input  logic                          issue_rd_is_int_i,
    input  logic [NumSrc*RegAddrW-1:0]    issue_rs_i,
    input  logic [NumSrc-1:0]             issue_rs_used_i,
    output logic                          fpu_valid_o,
    input  logic                          fpu_ready_i,
    output logic [TagW-1:0]               fpu_tag_o,
    input  logic                          fpu_out_valid_i,
    output logic                          fpu_out_ready_o,
    input  logic [FLEN-1:0]               fpu_result_i,
    input  logic [FlagsW-1:0]             fpu_status_i,
    input  logic [TagW-1:0]               fpu_tag_i,
    output logic                          fpr_we_o,
    output logic [RegAddrW-1:0]           fpr_waddr_o,
    output logic [FLEN-1:0]               fpr_wdata_o,
    output logic                          int_wb_valid_o,
    input  logic                          int_wb_ready_i,
    output logic [RegAddrW-1:0]           int_wb_addr_o,
    output logic [XLEN-1:0]               int_wb_data_o,
    output logic [FlagsW-1:0]             fflags_o,
    input  logic                          fflags_clr_i,
    output logic [CntW-1:0]               outstanding_o,
    output logic [NumRegs-1:0]            busy_o,
    output logic                          error_o
);

    logic [CntW-1:0]     r_outstanding, w_outstanding_n;
    logic [NumRegs-1:0]  r_busy, w_busy_n;
    logic [FlagsW-1:0]   r_fflags, w_fflags_n;
    logic                r_error, w_error_n;

    logic                w_hazard, w_full, w_issue_fire, w_res_fire;
    logic                w_res_is_int, w_res_busy, w_cnt_zero;
    logic [RegAddrW-1:0] w_res_addr;

    // Hazards look only at the registered scoreboard, so a register retiring this cycle still stalls.
    always_comb begin
        w_hazard = 1'b0;
        for (int s = 0; s < int'(NumSrc); s++) begin
            if (issue_rs_used_i[s] && r_busy[issue_rs_i[s*RegAddrW +: RegAddrW]]) begin
                w_hazard = 1'b1;
            end
        end
        if (!issue_rd_is_int_i && r_busy[issue_rd_i]) begin
            w_hazard = 1'b1;
        end
    end

    assign w_full       = (r_outstanding == CntW'(MaxOutstanding));
    assign w_cnt_zero   = (r_outstanding == '0);
    assign fpu_valid_o  = issue_valid_i & ~w_hazard & ~w_full;
    assign issue_ready_o = fpu_ready_i & ~w_hazard & ~w_full;
    assign fpu_tag_o    = {issue_rd_is_int_i, issue_rd_i};
    assign w_issue_fire = fpu_valid_o & fpu_ready_i;

    assign w_res_is_int    = fpu_tag_i[TagIntBit];
    assign w_res_addr      = fpu_tag_i[RegAddrW-1:0];
    assign w_res_busy      = r_busy[w_res_addr];
    assign fpu_out_ready_o = w_res_is_int ? int_wb_ready_i : 1'b1;
    assign w_res_fire      = fpu_out_valid_i & fpu_out_ready_o;

    assign fpr_we_o       = fpu_out_valid_i & ~w_res_is_int & w_res_busy;
    assign fpr_waddr_o    = w_res_addr;
    assign fpr_wdata_o    = fpu_result_i;
    assign int_wb_valid_o = fpu_out_valid_i & w_res_is_int;
    assign int_wb_addr_o  = w_res_addr;
    assign int_wb_data_o  = fpu_result_i[XLEN-1:0];

    // Next-state for counter, scoreboard (set beats clear), flags and error pulse.
    always_comb begin
        w_outstanding_n = r_outstanding;
        w_busy_n        = r_busy;
        w_fflags_n      = r_fflags;
        w_error_n       = 1'b0;

        if (w_issue_fire && !w_res_fire) begin
            w_outstanding_n = r_outstanding + CntW'(1);
        end else if (w_res_fire && !w_issue_fire && !w_cnt_zero) begin
            w_outstanding_n = r_outstanding - CntW'(1);
        end

        if (w_res_fire && !w_res_is_int) begin
            w_busy_n[w_res_addr] = 1'b0;
        end
        if (w_issue_fire && !issue_rd_is_int_i) begin
            w_busy_n[issue_rd_i] = 1'b1;
        end

        if (fflags_clr_i) begin
            w_fflags_n = w_res_fire ? fpu_status_i : '0;
        end else if (w_res_fire) begin
            w_fflags_n = r_fflags | fpu_status_i;
        end

        if (w_res_fire && ((!w_res_is_int && !w_res_busy) || w_cnt_zero)) begin
            w_error_n = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_outstanding <= '0;
            r_busy        <= '0;
            r_fflags      <= '0;
            r_error       <= 1'b0;
        end else begin
            r_outstanding <= w_outstanding_n;
            r_busy        <= w_busy_n;
            r_fflags      <= w_fflags_n;
            r_error       <= w_error_n;
        end
    end

    assign outstanding_o = r_outstanding;
    assign busy_o        = r_busy;
    assign fflags_o      = r_fflags;
    assign error_o       = r_error;

endmodule

// File: tb/tb_snitch_fpu_sequencer.sv
// Directed bench for snitch_fpu_sequencer: hazards, full stall, int writeback backpressure,
// flag accumulation/clear, tag errors, underflow and asynchronous reset.
module tb_snitch_fpu_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [4:0]  issue_rd_i;
    logic        issue_rd_is_int_i;
    logic [14:0] issue_rs_i;
    logic [2:0]  issue_rs_used_i;
    logic        fpu_valid_o;
    logic        fpu_ready_i;
    logic [5:0]  fpu_tag_o;
    logic        fpu_out_valid_i;
    logic        fpu_out_ready_o;
    logic [63:0] fpu_result_i;
    logic [4:0]  fpu_status_i;
    logic [5:0]  fpu_tag_i;
    logic        fpr_we_o;
    logic [4:0]  fpr_waddr_o;
    logic [63:0] fpr_wdata_o;
    logic        int_wb_valid_o;
    logic        int_wb_ready_i;
    logic [4:0]  int_wb_addr_o;
    logic [31:0] int_wb_data_o;
    logic [4:0]  fflags_o;
    logic        fflags_clr_i;
    logic [5:0]  outstanding_o;
    logic [31:0] busy_o;
    logic        error_o;

    int checks = 0;
    int errors = 0;

    snitch_fpu_sequencer #(.FLEN(64), .MaxOutstanding(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_rd_i(issue_rd_i), .issue_rd_is_int_i(issue_rd_is_int_i),
        .issue_rs_i(issue_rs_i), .issue_rs_used_i(issue_rs_used_i),
        .fpu_valid_o(fpu_valid_o), .fpu_ready_i(fpu_ready_i), .fpu_tag_o(fpu_tag_o),
        .fpu_out_valid_i(fpu_out_valid_i), .fpu_out_ready_o(fpu_out_ready_o),
        .fpu_result_i(fpu_result_i), .fpu_status_i(fpu_status_i), .fpu_tag_i(fpu_tag_i),
        .fpr_we_o(fpr_we_o), .fpr_waddr_o(fpr_waddr_o), .fpr_wdata_o(fpr_wdata_o),
        .int_wb_valid_o(int_wb_valid_o), .int_wb_ready_i(int_wb_ready_i),
        .int_wb_addr_o(int_wb_addr_o), .int_wb_data_o(int_wb_data_o),
        .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i),
        .outstanding_o(outstanding_o), .busy_o(busy_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_issue(input logic [4:0] rd, input logic is_int,
                             input logic [14:0] rs, input logic [2:0] used);
        issue_valid_i     = 1'b1;
        issue_rd_i        = rd;
        issue_rd_is_int_i = is_int;
        issue_rs_i        = rs;
        issue_rs_used_i   = used;
    endtask

    task automatic clr_issue();
        issue_valid_i   = 1'b0;
        issue_rs_used_i = '0;
    endtask

    task automatic set_res(input logic [5:0] tag, input logic [63:0] data, input logic [4:0] st);
        fpu_out_valid_i = 1'b1;
        fpu_tag_i       = tag;
        fpu_result_i    = data;
        fpu_status_i    = st;
    endtask

    task automatic clr_res();
        fpu_out_valid_i = 1'b0;
        fpu_status_i    = '0;
    endtask

    initial begin
        rst_i = 1'b1;
        issue_valid_i = 1'b0; issue_rd_i = '0; issue_rd_is_int_i = 1'b0;
        issue_rs_i = '0; issue_rs_used_i = '0; fpu_ready_i = 1'b1;
        fpu_out_valid_i = 1'b0; fpu_result_i = '0; fpu_status_i = '0; fpu_tag_i = '0;
        int_wb_ready_i = 1'b1; fflags_clr_i = 1'b0;
        #2;
        check("rst_outstanding", 64'(outstanding_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_fflags", 64'(fflags_o), 64'd0);
        check("rst_error", 64'(error_o), 64'd0);
        tick();
        rst_i = 1'b0;

        // RAW hazard on rd=3
        set_issue(5'd3, 1'b0, 15'd0, 3'b000);
        #1;
        check("raw_first_valid", 64'(fpu_valid_o), 64'd1);
        check("raw_first_ready", 64'(issue_ready_o), 64'd1);
        check("raw_first_tag", 64'(fpu_tag_o), 64'h03);
        tick();
        set_issue(5'd4, 1'b0, 15'd3, 3'b001);
        #1;
        check("raw_busy", 64'(busy_o), 64'h8);
        check("raw_outstanding", 64'(outstanding_o), 64'd1);
        check("raw_held_ready", 64'(issue_ready_o), 64'd0);
        check("raw_held_valid", 64'(fpu_valid_o), 64'd0);
        tick();
        set_res(6'h03, 64'h1111_2222_3333_4444, 5'h00);
        #1;
        check("raw_fpr_we", 64'(fpr_we_o), 64'd1);
        check("raw_waddr", 64'(fpr_waddr_o), 64'd3);
        check("raw_wdata", fpr_wdata_o, 64'h1111_2222_3333_4444);
        check("raw_retire_cycle_ready", 64'(issue_ready_o), 64'd0);
        tick();
        clr_res();
        #1;
        check("raw_after_ready", 64'(issue_ready_o), 64'd1);
        tick();
        clr_issue();
        #1;
        check("raw_second_busy", 64'(busy_o), 64'h10);
        check("raw_second_outstanding", 64'(outstanding_o), 64'd1);
        set_res(6'h04, 64'd0, 5'h00);
        tick();
        clr_res();
        #1;
        check("raw_drained", 64'(outstanding_o), 64'd0);

        // Fill to MaxOutstanding
        for (int i = 0; i < 8; i++) begin
            set_issue(5'(8 + i), 1'b0, 15'd0, 3'b000);
            tick();
        end
        set_issue(5'd16, 1'b0, 15'd0, 3'b000);
        set_res(6'd8, 64'd0, 5'h00);
        #1;
        check("full_outstanding", 64'(outstanding_o), 64'd8);
        check("full_busy", 64'(busy_o), 64'h0000_FF00);
        check("full_ready", 64'(issue_ready_o), 64'd0);
        check("full_valid", 64'(fpu_valid_o), 64'd0);
        tick();
        clr_res();
        #1;
        check("full_after_one_outstanding", 64'(outstanding_o), 64'd7);
        check("full_ninth_ready", 64'(issue_ready_o), 64'd1);
        tick();
        clr_issue();
        #1;
        check("full_ninth_outstanding", 64'(outstanding_o), 64'd8);
        check("full_ninth_busy", 64'(busy_o), 64'h0001_FE00);
        for (int i = 9; i <= 16; i++) begin
            set_res(6'(i), 64'd0, 5'h00);
            tick();
        end
        clr_res();
        #1;
        check("full_drain_outstanding", 64'(outstanding_o), 64'd0);
        check("full_drain_busy", 64'(busy_o), 64'd0);

        // Integer writeback backpressure
        set_issue(5'd5, 1'b1, 15'd0, 3'b000);
        #1;
        check("int_tag", 64'(fpu_tag_o), 64'h25);
        tick();
        clr_issue();
        int_wb_ready_i = 1'b0;
        set_res(6'h25, 64'h0123_4567_DEAD_BEEF, 5'h01);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("int_stall_out_ready", 64'(fpu_out_ready_o), 64'd0);
            check("int_stall_wb_valid", 64'(int_wb_valid_o), 64'd1);
            tick();
        end
        int_wb_ready_i = 1'b1;
        #1;
        check("int_accept_out_ready", 64'(fpu_out_ready_o), 64'd1);
        check("int_accept_addr", 64'(int_wb_addr_o), 64'd5);
        check("int_accept_data", 64'(int_wb_data_o), 64'hDEAD_BEEF);
        check("int_accept_no_fpr_we", 64'(fpr_we_o), 64'd0);
        tick();
        clr_res();
        #1;
        check("int_outstanding", 64'(outstanding_o), 64'd0);
        check("fflags_first", 64'(fflags_o), 64'h01);

        // Flag accumulation and clear
        set_issue(5'd6, 1'b1, 15'd0, 3'b000);
        tick();
        set_issue(5'd7, 1'b1, 15'd0, 3'b000);
        tick();
        clr_issue();
        set_res(6'h26, 64'd0, 5'h10);
        tick();
        #1;
        check("fflags_or", 64'(fflags_o), 64'h11);
        set_res(6'h27, 64'd0, 5'h04);
        fflags_clr_i = 1'b1;
        tick();
        clr_res();
        fflags_clr_i = 1'b0;
        #1;
        check("fflags_clr_load", 64'(fflags_o), 64'h04);
        check("fflags_outstanding", 64'(outstanding_o), 64'd0);
        fflags_clr_i = 1'b1;
        tick();
        fflags_clr_i = 1'b0;
        #1;
        check("fflags_clr_only", 64'(fflags_o), 64'h00);

        // FP result for a register that is not busy
        set_issue(5'd1, 1'b1, 15'd0, 3'b000);
        tick();
        clr_issue();
        set_res(6'h07, 64'h55, 5'h00);
        #1;
        check("tagerr_no_we", 64'(fpr_we_o), 64'd0);
        check("tagerr_out_ready", 64'(fpu_out_ready_o), 64'd1);
        check("tagerr_error_before", 64'(error_o), 64'd0);
        tick();
        clr_res();
        #1;
        check("tagerr_error_pulse", 64'(error_o), 64'd1);
        check("tagerr_outstanding", 64'(outstanding_o), 64'd0);
        tick();
        check("tagerr_error_clears", 64'(error_o), 64'd0);

        // Result with nothing in flight
        set_res(6'h21, 64'd0, 5'h00);
        tick();
        clr_res();
        #1;
        check("underflow_error", 64'(error_o), 64'd1);
        check("underflow_outstanding", 64'(outstanding_o), 64'd0);
        tick();

        // Simultaneous issue and retire
        set_issue(5'd9, 1'b0, 15'd0, 3'b000);
        tick();
        set_issue(5'd10, 1'b0, 15'd0, 3'b000);
        set_res(6'd9, 64'd0, 5'h00);
        tick();
        clr_issue();
        clr_res();
        #1;
        check("simul_outstanding", 64'(outstanding_o), 64'd1);
        check("simul_busy", 64'(busy_o), 64'h400);
        set_res(6'd10, 64'd0, 5'h00);
        tick();
        clr_res();
        #1;
        check("simul_drained", 64'(outstanding_o), 64'd0);

        // Asynchronous reset mid-operation
        set_issue(5'd3, 1'b0, 15'd0, 3'b000);
        tick();
        set_issue(5'd4, 1'b0, 15'd0, 3'b000);
        tick();
        set_issue(5'd1, 1'b1, 15'd0, 3'b000);
        tick();
        set_issue(5'd2, 1'b1, 15'd0, 3'b000);
        tick();
        clr_issue();
        #1;
        check("prerst_outstanding", 64'(outstanding_o), 64'd4);
        check("prerst_busy", 64'(busy_o), 64'h18);
        rst_i = 1'b1;
        #1;
        check("async_rst_outstanding", 64'(outstanding_o), 64'd0);
        check("async_rst_busy", 64'(busy_o), 64'd0);
        check("async_rst_fflags", 64'(fflags_o), 64'd0);
        check("async_rst_error", 64'(error_o), 64'd0);
        tick();
        rst_i = 1'b0;
        set_res(6'h03, 64'd0, 5'h00);
        #1;
        check("postrst_no_we", 64'(fpr_we_o), 64'd0);
        tick();
        clr_res();
        #1;
        check("postrst_error", 64'(error_o), 64'd1);
        check("postrst_outstanding", 64'(outstanding_o), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
